gene_attractor_detect: RTL and testbench

- Parametrised attractor detector for the gene-network simulator.
- Watches the stream of network state vectors produced by the update engine.
- Reports the first recurrence of any state within a window of the last MAX_PERIOD states: fixed points (period 1) and limit cycles up to MAX_PERIOD.
- Also reports attractor period and transient length, and flags a timeout when no attractor appears within MAX_STEPS samples.

---
 rtl/gene_attractor_detect.sv | 189 ++++++++++++++++++
 tb/tb_gene_attractor_detect.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gene_attractor_detect.sv
// gene_attractor_detect
//
// Watches the stream of network state vectors from the gene-network update engine
// and reports the first recurrence of any state within the last MAX_PERIOD accepted
// samples. It detects fixed points (period 1) and limit cycles up to MAX_PERIOD. It
// also reports the attractor period and the transient length. If MAX_STEPS samples
// are accepted without a recurrence, it flags a timeout instead.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      one-cycle pulse: clear history/results and begin a new trajectory
//   x_valid    x carries a new network state this cycle
//   x          current network state (WIDTH genes)
//   busy       high while tracking a trajectory
//   found      attractor detected (sticky until start/rst)
//   timeout    MAX_STEPS reached without detection (sticky until start/rst)
//   period     detected period, 0 when not found
//   transient  samples preceding the first occurrence of the recurring state
//   steps      accepted samples since start (saturating)
//
// All outputs are registered. A deciding sample accepted on edge N is reflected on
// found/timeout/period/transient immediately after edge N.

module gene_attractor_detect #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_PERIOD = 8,
    parameter int unsigned STEP_W     = 8,
    parameter int unsigned MAX_STEPS  = 200,
    localparam int unsigned PW        = $clog2(MAX_PERIOD + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              x_valid,
    input  logic [WIDTH-1:0]  x,
    output logic              busy,
    output logic              found,
    output logic              timeout,
    output logic [PW-1:0]     period,
    output logic [STEP_W-1:0] transient,
    output logic [STEP_W-1:0] steps
);

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StFound,
        StTimeout
    } state_e;

    state_e state_q, state_d;

    // hist_q[k] holds the sample accepted k samples ago.
    logic [WIDTH-1:0]    hist_q  [1:MAX_PERIOD];
    logic [WIDTH-1:0]    hist_d  [1:MAX_PERIOD];
    logic [WIDTH-1:0]    hist_sh [1:MAX_PERIOD];
    logic [MAX_PERIOD:1] vld_q, vld_d, vld_sh;

    logic [STEP_W-1:0] steps_q, steps_d, steps_inc;
    logic [STEP_W-1:0] transient_q, transient_d;
    logic [PW-1:0]     period_q, period_d;
    logic              found_q, found_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, busy_d;

    logic          match;
    logic [PW-1:0] match_k;

    // Parallel compare against every valid history entry. The loop runs from the
    // oldest entry down to the newest, so the smallest matching index wins. That
    // yields the fundamental period, never a multiple of it.
    always_comb begin
        match   = 1'b0;
        match_k = '0;
        for (int k = int'(MAX_PERIOD); k >= 1; k--) begin
            if (vld_q[k] && (hist_q[k] == x)) begin
                match   = 1'b1;
                match_k = PW'(k);
            end
        end
    end

    // History as it would look after accepting x.
    always_comb begin
        hist_sh    = hist_q;
        vld_sh     = vld_q;
        hist_sh[1] = x;
        vld_sh[1]  = 1'b1;
        for (int k = 2; k <= int'(MAX_PERIOD); k++) begin
            hist_sh[k] = hist_q[k-1];
            vld_sh[k]  = vld_q[k-1];
        end
    end

    assign steps_inc = (steps_q == '1) ? steps_q : steps_q + STEP_W'(1);

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        vld_d       = vld_q;
        steps_d     = steps_q;
        transient_d = transient_q;
        period_d    = period_q;
        found_d     = found_q;
        timeout_d   = timeout_q;

        if (start) begin
            state_d     = StTrack;
            vld_d       = '0;
            steps_d     = '0;
            transient_d = '0;
            period_d    = '0;
            found_d     = 1'b0;
            timeout_d   = 1'b0;
            // A sample that arrives with start is sample 1. The history is empty, so
            // no compare is made.
            if (x_valid) begin
                hist_d[1] = x;
                vld_d[1]  = 1'b1;
                steps_d   = STEP_W'(1);
                if (STEP_W'(1) == STEP_W'(MAX_STEPS)) begin
                    timeout_d = 1'b1;
                    state_d   = StTimeout;
                end
            end
        end else begin
            case (state_q)
                StTrack: begin
                    if (x_valid) begin
                        hist_d  = hist_sh;
                        vld_d   = vld_sh;
                        steps_d = steps_inc;
                        if (match) begin
                            // The first occurrence of x was (steps_q - k) samples in.
                            // This difference cannot underflow: k is at most the
                            // number of valid entries, which is at most steps_q.
                            period_d    = match_k;
                            transient_d = steps_q - STEP_W'(match_k);
                            found_d     = 1'b1;
                            state_d     = StFound;
                        end else if (steps_inc == STEP_W'(MAX_STEPS)) begin
                            timeout_d = 1'b1;
                            state_d   = StTimeout;
                        end
                    end
                end
                // IDLE waits for start. FOUND and TIMEOUT hold every output.
                default: ;
            endcase
        end

        busy_d = (state_d == StTrack);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            vld_q       <= '0;
            steps_q     <= '0;
            transient_q <= '0;
            period_q    <= '0;
            found_q     <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 1; k <= int'(MAX_PERIOD); k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            vld_q       <= vld_d;
            steps_q     <= steps_d;
            transient_q <= transient_d;
            period_q    <= period_d;
            found_q     <= found_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign found     = found_q;
    assign timeout   = timeout_q;
    assign period    = period_q;
    assign transient = transient_q;
    assign steps     = steps_q;

endmodule

// File: tb/tb_gene_attractor_detect.sv
// Scoreboard bench for gene_attractor_detect (WIDTH=8, MAX_PERIOD=8, STEP_W=8,
// MAX_STEPS=20). Stimulus pushes expected output records into a queue. A monitor
// pops one record on each rising edge of found|timeout, and one on each explicit
// snapshot request, then compares it with the DUT outputs at the falling clock edge.

module tb_gene_attractor_detect;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned MAX_PERIOD = 8;
    localparam int unsigned STEP_W     = 8;
    localparam int unsigned MAX_STEPS  = 20;
    localparam int unsigned PW         = $clog2(MAX_PERIOD + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              x_valid = 1'b0;
    logic [WIDTH-1:0]  x = '0;
    logic              busy, found, timeout;
    logic [PW-1:0]     period;
    logic [STEP_W-1:0] transient, steps;

    gene_attractor_detect #(
        .WIDTH      (WIDTH),
        .MAX_PERIOD (MAX_PERIOD),
        .STEP_W     (STEP_W),
        .MAX_STEPS  (MAX_STEPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_valid   (x_valid),
        .x         (x),
        .busy      (busy),
        .found     (found),
        .timeout   (timeout),
        .period    (period),
        .transient (transient),
        .steps     (steps)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              found;
        logic              timeout;
        logic [PW-1:0]     period;
        logic [STEP_W-1:0] transient;
        logic [STEP_W-1:0] steps;
        logic              busy;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    checks = 0;
    int    errors = 0;
    logic  snap = 1'b0;

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input string name, input logic f, input logic t, input int p,
                        input int tr, input int s, input logic b);
        exp_t e;
        e.found     = f;
        e.timeout   = t;
        e.period    = PW'(p);
        e.transient = STEP_W'(tr);
        e.steps     = STEP_W'(s);
        e.busy      = b;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Check the outputs as they stand after the most recent clock edge.
    task automatic expect_now(input string name, input logic f, input logic t, input int p,
                              input int tr, input int s, input logic b);
        push(name, f, t, p, tr, s, b);
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] v);
        x_valid = 1'b1;
        x       = v;
        tick();
        x_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_pulse(input logic with_x, input logic [WIDTH-1:0] v);
        start   = 1'b1;
        x_valid = with_x;
        x       = v;
        tick();
        start   = 1'b0;
        x_valid = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic done_prev;
        logic done;
        exp_t e;
        string n;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            done = found | timeout;
            if ((done && !done_prev) || snap) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: found=%0b timeout=%0b period=%0d steps=%0d, no expectation queued",
                             found, timeout, period, steps);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (found !== e.found || timeout !== e.timeout || period !== e.period ||
                        transient !== e.transient || steps !== e.steps || busy !== e.busy) begin
                        errors++;
                        $display("FAIL %s: got f=%0b t=%0b p=%0d tr=%0d s=%0d b=%0b, want f=%0b t=%0b p=%0d tr=%0d s=%0d b=%0b",
                                 n, found, timeout, period, transient, steps, busy,
                                 e.found, e.timeout, e.period, e.transient, e.steps, e.busy);
                    end
                end
            end
            done_prev = done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        tick();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        expect_now("reset", 0, 0, 0, 0, 0, 0);

        // Fixed point: 0x22 repeats at once.
        start_pulse(1'b0, '0);
        send(8'h11);
        send(8'h22);
        push("fixed_point", 1, 0, 1, 1, 3, 0);
        send(8'h22);
        idle(1);

        // Period 2, then later samples must be ignored.
        start_pulse(1'b0, '0);
        send(8'h00);
        send(8'hA5);
        send(8'h3C);
        push("period2", 1, 0, 2, 1, 4, 0);
        send(8'hA5);
        send(8'h11);
        send(8'h22);
        send(8'h11);
        expect_now("period2_hold", 1, 0, 2, 1, 4, 0);

        // Longest detectable period.
        start_pulse(1'b0, '0);
        for (int i = 1; i <= 8; i++) send(8'(i));
        push("period8", 1, 0, 8, 0, 9, 0);
        send(8'h01);
        idle(1);

        // Period 9 is out of reach, so the trajectory times out on sample 20.
        start_pulse(1'b0, '0);
        for (int i = 0; i < 19; i++) send(8'((i % 9) + 1));
        expect_now("timeout_pre", 0, 0, 0, 0, 19, 1);
        push("timeout", 0, 1, 0, 0, 20, 0);
        send(8'h02);
        idle(2);

        // Period 2 with x_valid gaps.
        start_pulse(1'b0, '0);
        send(8'h00);
        idle(3);
        send(8'hA5);
        idle(3);
        send(8'h3C);
        idle(2);
        expect_now("gaps_mid", 0, 0, 0, 0, 3, 1);
        push("gaps_period2", 1, 0, 2, 1, 4, 0);
        send(8'hA5);
        idle(1);

        // Restart with a sample in the same cycle, mid-run.
        start_pulse(1'b0, '0);
        for (int i = 1; i <= 5; i++) send(8'(i * 16));
        expect_now("pre_restart", 0, 0, 0, 0, 5, 1);
        start_pulse(1'b1, 8'h7E);
        expect_now("restart", 0, 0, 0, 0, 1, 1);
        send(8'h10);                       // matches only the stale history
        expect_now("history_cleared", 0, 0, 0, 0, 2, 1);
        push("restart_period2", 1, 0, 2, 0, 3, 0);
        send(8'h7E);
        idle(1);
        start_pulse(1'b1, 8'h7E);
        expect_now("restart2", 0, 0, 0, 0, 1, 1);
        push("restart_fixed", 1, 0, 1, 0, 2, 0);
        send(8'h7E);
        idle(1);

        // Reset with a matching sample pending.
        start_pulse(1'b0, '0);
        send(8'h05);
        send(8'h06);
        send(8'h07);
        send(8'h08);
        rst     = 1'b1;
        x_valid = 1'b1;
        x       = 8'h07;
        tick();
        rst     = 1'b0;
        x_valid = 1'b0;
        expect_now("reset_mid", 0, 0, 0, 0, 0, 0);
        send(8'h08);
        expect_now("reset_idle", 0, 0, 0, 0, 0, 0);

        idle(3);
        while (exp_q.size() != 0) begin
            string n;
            n = name_q.pop_front();
            void'(exp_q.pop_front());
            checks++;
            errors++;
            $display("FAIL %s: expected output event never occurred, want 1 event got 0", n);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
